// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the MEM stage, the host/loader port and the single-port data_memory.
// The slave modport is the arbiter's view; the master modport is the environment driving it.
interface data_mem_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 20
);
  logic                     cpu_req;
  logic                     cpu_we;
  logic                     cpu_be;
  logic [ADDRESS_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0]    cpu_wdata;
  logic [DATA_WIDTH-1:0]    cpu_rdata;
  logic                     cpu_stall;

  logic                     host_req;
  logic                     host_we;
  logic                     host_lock;
  logic [ADDRESS_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0]    host_wdata;
  logic                     host_gnt;
  logic                     host_rvalid;
  logic [DATA_WIDTH-1:0]    host_rdata;

  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_we;
  logic                     mem_re;
  logic                     mem_be;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output host_gnt, host_rvalid, host_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re, mem_be
  );

  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re, mem_be
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Single-port data_memory arbiter: MEM stage vs host/loader, anti-starvation wait counter, bounded lock bursts.
// Optional ARB_PERF_CNT_EN adds perf_stall_cnt / perf_host_cnt performance counters.
module data_mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 20,
  parameter int MAX_WAIT      = 4,
  parameter int LOCK_MAX      = 16
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_host_cnt
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(MAX_WAIT);
  localparam logic [LOCK_W-1:0] LOCK_TOP = LOCK_W'(LOCK_MAX);

  typedef enum logic [1:0] {IDLE, CPU, HOST, LOCK} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_HOST} grant_t;

  state_t              state, state_next;
  grant_t              grant;
  logic [WAIT_W-1:0]   wait_cnt, wait_next;
  logic [LOCK_W-1:0]   lock_cnt, lock_next;
  logic                lock_release;

  // Grant decision for the current cycle; reset drops ownership immediately.
  always_comb begin
    grant = GNT_NONE;
    if (!rst)
      grant = GNT_NONE;
    else if (state == LOCK && bus.host_req && bus.host_lock && lock_cnt < LOCK_TOP)
      grant = GNT_HOST;
    else if (bus.host_req && wait_cnt == WAIT_TOP)
      grant = GNT_HOST;
    else if (bus.cpu_req)
      grant = GNT_CPU;
    else if (bus.host_req)
      grant = GNT_HOST;
  end

  // A CPU slot forced by an exhausted lock burst leaves the host owed the very next slot.
  assign lock_release = (grant == GNT_CPU) && bus.host_req && bus.host_lock && (lock_cnt == LOCK_TOP);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_next = IDLE;
    wait_next  = wait_cnt;
    lock_next  = lock_cnt;

    unique case (grant)
      GNT_HOST: state_next = bus.host_lock ? LOCK : HOST;
      GNT_CPU:  state_next = CPU;
      default:  state_next = IDLE;
    endcase

    if (!bus.host_req || grant == GNT_HOST)
      wait_next = '0;
    else if (lock_release)
      wait_next = WAIT_TOP;
    else if (wait_cnt != WAIT_TOP)
      wait_next = wait_cnt + 1'b1;

    if (!bus.host_req || !bus.host_lock || grant == GNT_CPU)
      lock_next = '0;
    else if (grant == GNT_HOST && lock_cnt != LOCK_TOP)
      lock_next = lock_cnt + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      lock_cnt    <= '0;
      bus.host_rvalid <= 1'b0;
      bus.host_rdata  <= '0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_next;
      lock_cnt    <= lock_next;
      bus.host_rvalid <= (grant == GNT_HOST) && !bus.host_we;
      if (grant == GNT_HOST && !bus.host_we)
        bus.host_rdata <= bus.mem_rdata;
    end
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_be    = 1'b0;
    bus.host_gnt  = 1'b0;
    bus.cpu_stall = 1'b0;
    unique case (grant)
      GNT_HOST: begin
        bus.mem_addr  = bus.host_addr;
        bus.mem_wdata = bus.host_wdata;
        bus.mem_we    = bus.host_we;
        bus.mem_re    = !bus.host_we;
        bus.host_gnt  = 1'b1;
        bus.cpu_stall = bus.cpu_req;
      end
      GNT_CPU: begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_we    = bus.cpu_we;
        bus.mem_re    = !bus.cpu_we;
        bus.mem_be    = bus.cpu_be;
      end
      default: ;
    endcase
  end

  assign bus.cpu_rdata = bus.mem_rdata;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_host_cnt  <= '0;
    end else begin
      if (bus.cpu_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (bus.host_gnt)  perf_host_cnt  <= perf_host_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: expected bus outputs are queued as stimulus is driven
// and popped at the following falling edge.
module tb_data_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_host_cnt;
`endif

  data_mem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_WAIT(4), .LOCK_MAX(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_host_cnt  (perf_host_cnt)
`endif
  );

  // Read-only memory model: a fixed word at 0x20, an address-derived pattern elsewhere.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 20'h00020) return 32'h0000_0ABC;
    return {12'h5A5, a};
  endfunction
  assign bus.mem_rdata = mem_word(bus.mem_addr);

  typedef struct {
    string          tag;
    logic [63:0]    outs;
    logic           rd_care;
    logic [DW-1:0]  rdata;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] pk(input logic gnt, stall, we, re, be, rv,
                                     input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    return {6'b0, gnt, stall, we, re, be, rv, addr, wdata};
  endfunction

  function automatic logic [63:0] observed();
    return pk(bus.host_gnt, bus.cpu_stall, bus.mem_we, bus.mem_re, bus.mem_be,
              bus.host_rvalid, bus.mem_addr, bus.mem_wdata);
  endfunction

  task automatic push(input string tag, input logic [63:0] outs,
                      input logic rd_care = 1'b0, input logic [DW-1:0] rdata = '0);
    exp_t e;
    e.tag = tag; e.outs = outs; e.rd_care = rd_care; e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check(e.tag, observed(), e.outs);
    if (e.rd_care) check({e.tag, "_rdata"}, 64'(bus.host_rdata), 64'(e.rdata));
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, we, be, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_be = be; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
  endtask

  task automatic set_host(input logic req, we, lock, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus.host_req = req; bus.host_we = we; bus.host_lock = lock; bus.host_addr = addr; bus.host_wdata = wdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beats;
    logic host_slot;
    set_cpu(0, 0, 0, '0, '0);
    set_host(0, 0, 0, '0, '0);

    // Reset state: no requests, all outputs low, read path cleared.
    #12;
    push("reset_outs", pk(0, 0, 0, 0, 0, 0, '0, '0), 1'b1, '0);
    #1 compare_head();
    @(posedge clk); #1;
    rst = 1'b1;

    // CPU write alone.
    set_cpu(1, 1, 1, 20'h10, 32'h5);
    push("cpu_only_write", pk(0, 0, 1, 0, 1, 0, 20'h10, 32'h5));
    cycle();

    // Host read alone, data one cycle later.
    set_cpu(0, 0, 0, '0, '0);
    set_host(1, 0, 0, 20'h20, '0);
    push("host_read_gnt", pk(1, 0, 0, 1, 0, 0, 20'h20, '0));
    cycle();
    set_host(0, 0, 0, '0, '0);
    push("host_read_rvalid", pk(0, 0, 0, 0, 0, 1, '0, '0), 1'b1, 32'h0000_0ABC);
    cycle();

    // Contention: host forced in every fifth cycle.
    do_reset();
    set_cpu(1, 0, 1, 20'h100, '0);
    set_host(1, 1, 0, 20'h200, 32'hBEEF);
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) push($sformatf("contend_host_%0d", i), pk(1, 1, 1, 0, 0, 0, 20'h200, 32'hBEEF));
      else            push($sformatf("contend_cpu_%0d", i),  pk(0, 0, 0, 1, 1, 0, 20'h100, '0));
      if (i == 0) begin
        @(negedge clk);
        check("cpu_rdata_pass", 64'(bus.cpu_rdata), 64'(mem_word(20'h100)));
        compare_head();
        @(posedge clk); #1;
      end else begin
        cycle();
      end
    end
`ifdef ARB_PERF_CNT_EN
    check("perf_host_cnt", 64'(perf_host_cnt), 64'd2);
    check("perf_stall_cnt", 64'(perf_stall_cnt), 64'd2);
`endif
    set_cpu(0, 0, 0, '0, '0);
    set_host(0, 0, 0, '0, '0);
    push("contend_idle", pk(0, 0, 0, 0, 0, 0, '0, '0));
    cycle();

    // Locked burst of 20 beats against a steady CPU request.
    do_reset();
    beats = 0;
    set_cpu(1, 0, 1, 20'h100, '0);
    set_host(1, 1, 1, 20'h300, 32'h1000);
    for (int c = 0; c < 25; c++) begin
      host_slot = (c >= 4 && c <= 19) || (c >= 21);
      if (host_slot)
        push($sformatf("lock_host_c%0d", c), pk(1, 1, 1, 0, 0, 0, 20'h300 + AW'(beats), 32'h1000 + DW'(beats)));
      else
        push($sformatf("lock_cpu_c%0d", c), pk(0, 0, 0, 1, 1, 0, 20'h100, '0));
      cycle();
      if (host_slot) begin
        beats++;
        set_host(1, 1, 1, 20'h300 + AW'(beats), 32'h1000 + DW'(beats));
      end
    end
    set_host(0, 0, 0, '0, '0);
    push("lock_done_cpu", pk(0, 0, 0, 1, 1, 0, 20'h100, '0));
    cycle();

    // Asynchronous reset in the middle of a locked read burst.
    do_reset();
    set_cpu(0, 0, 0, '0, '0);
    set_host(1, 0, 1, 20'h20, '0);
    push("rst_mid_first", pk(1, 0, 0, 1, 0, 0, 20'h20, '0));
    cycle();
    set_cpu(1, 0, 1, 20'h100, '0);
    set_host(1, 0, 1, 20'h21, '0);
    push("rst_mid_locked", pk(1, 1, 0, 1, 0, 1, 20'h21, '0), 1'b1, 32'h0000_0ABC);
    @(negedge clk);
    compare_head();
    #2 rst = 1'b0;
    push("rst_mid_async", pk(0, 0, 0, 0, 0, 0, '0, '0), 1'b1, '0);
    #1 compare_head();
    @(posedge clk); #1;
    rst = 1'b1;
    set_cpu(0, 0, 0, '0, '0);
    set_host(0, 0, 0, '0, '0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
